ssd_mux_driver: RTL and testbench

Time-multiplexed, parametrised seven-segment display driver for NUM_DIGITS common-anode digits. It takes a packed vector of 4-bit digit codes plus per-digit decimal-point and blank flags, and double-buffers them so a frame never tears. It scans one digit per refresh slot and drives active-low anode, segment and decimal-point outputs with a ghost-suppression guard cycle. It sits between the temperature-conversion datapath (BCD or hex digits) and the board display pins.

---
 rtl/ssd_pkg.sv | 32 +++
 rtl/ssd_decode.sv | 38 +++
 rtl/ssd_mux_driver.sv | 168 ++++++++++++++++
 tb/tb_ssd_mux_driver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared types and active-low segment patterns for the seven-segment driver.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package ssd_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    // A slot starts with one dark guard cycle, then drives the anode.
    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b0000011;
    localparam seg_t SEG_C     = 7'b1000110;
    localparam seg_t SEG_D     = 7'b0100001;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_F     = 7'b0001110;
    localparam seg_t SEG_BLANK = 7'h7F;

endpackage

// File: rtl/ssd_decode.sv
// Combinational nibble-to-segment decoder. Letters A-F only appear in hex
// mode; a suppressed digit is always dark.
module ssd_decode
    import ssd_pkg::*;
(
    input  nibble_t code,
    input  logic    hex_mode,
    input  logic    suppress,
    output seg_t    seg
);

    // Map the code to its pattern, dark when suppressed or a letter in decimal mode.
    always_comb begin
        // NOTE: seg gets a default before the case so every path assigns it and no latch is inferred.
        seg = SEG_BLANK;
        if (!suppress) begin
            case (code)
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = hex_mode ? SEG_A : SEG_BLANK;
                4'hB: seg = hex_mode ? SEG_B : SEG_BLANK;
                4'hC: seg = hex_mode ? SEG_C : SEG_BLANK;
                4'hD: seg = hex_mode ? SEG_D : SEG_BLANK;
                4'hE: seg = hex_mode ? SEG_E : SEG_BLANK;
                4'hF: seg = hex_mode ? SEG_F : SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/ssd_mux_driver.sv
// Time-multiplexed common-anode seven-segment driver. Inputs are captured
// into a shadow register on load and committed to the display register only
// when the scan wraps to digit 0, so a frame never tears. Outputs are
// registered and computed from next-state values so they line up with cnt/idx.
module ssd_mux_driver
    import ssd_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    hex_mode,
    input  logic                    lzs_en,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [6:0]              cc_out,
    output logic                    dp_out,
    output logic                    frame_tick
);

    localparam int               CNT_W    = $clog2(REFRESH_DIV);
    localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    slot_state_t             state, state_nxt;
    logic                    pending, pending_nxt;
    logic                    cnt_wrap, frame_wrap, commit;

    logic [4*NUM_DIGITS-1:0] sh_digits, disp_digits, disp_digits_nxt;
    logic [NUM_DIGITS-1:0]   sh_dp, disp_dp, disp_dp_nxt;
    logic [NUM_DIGITS-1:0]   sh_blank, disp_blank, disp_blank_nxt;
    logic                    sh_hex, disp_hex, disp_hex_nxt;
    logic                    sh_lzs, disp_lzs, disp_lzs_nxt;

    logic [NUM_DIGITS-1:0]   lz_supp;
    logic                    lz_run, zero_like;
    logic [NUM_DIGITS-1:0]   an_nxt;
    nibble_t                 sel_code;
    logic                    sel_dp, sel_blank, sel_suppress;
    seg_t                    sel_seg;

    // Slot counter, digit index and commit/pending bookkeeping.
    always_comb begin
        cnt_wrap    = (cnt == CNT_LAST);
        frame_wrap  = cnt_wrap && (idx == IDX_LAST);
        commit      = frame_wrap && pending;
        cnt_nxt     = cnt_wrap ? '0 : cnt + 1'b1;
        idx_nxt     = idx;
        if (cnt_wrap) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
        // A load on the commit edge re-arms pending for the following frame.
        pending_nxt = load || (pending && !commit);
    end

    // Slot FSM: one guard cycle, then drive until the slot counter wraps.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_GUARD: state_nxt = ST_DRIVE;
            ST_DRIVE: if (cnt_wrap) state_nxt = ST_GUARD;
            default:  state_nxt = ST_GUARD;
        endcase
    end

    // Display register contents as they will be after this edge.
    always_comb begin
        disp_digits_nxt = commit ? sh_digits : disp_digits;
        disp_dp_nxt     = commit ? sh_dp     : disp_dp;
        disp_blank_nxt  = commit ? sh_blank  : disp_blank;
        disp_hex_nxt    = commit ? sh_hex    : disp_hex;
        disp_lzs_nxt    = commit ? sh_lzs    : disp_lzs;
    end

    // Leading-zero suppression from the top digit down; digit 0 always shows.
    always_comb begin
        lz_run    = disp_lzs_nxt;
        zero_like = 1'b0;
        lz_supp   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_like  = disp_blank_nxt[i] ||
                         ((disp_digits_nxt[4*i +: 4] == 4'h0) && !disp_dp_nxt[i]);
            lz_run     = lz_run && zero_like;
            lz_supp[i] = lz_run && (i != 0);
        end
    end

    // Select the digit for the upcoming cycle and build the anode pattern.
    always_comb begin
        sel_code     = disp_digits_nxt[4*int'(idx_nxt) +: 4];
        sel_dp       = disp_dp_nxt[idx_nxt];
        sel_blank    = disp_blank_nxt[idx_nxt];
        sel_suppress = sel_blank || lz_supp[idx_nxt];
        an_nxt       = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_nxt[i] = !((state_nxt == ST_DRIVE) && (idx_nxt == IDX_W'(i)));
        end
    end

    ssd_decode u_decode (
        .code     (sel_code),
        .hex_mode (disp_hex_nxt),
        .suppress (sel_suppress),
        .seg      (sel_seg)
    );

    // Scan state, shadow capture and frame-boundary commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            state       <= ST_GUARD;
            pending     <= 1'b0;
            // NOTE: shadow and display registers are reset with every digit blanked so the panel stays dark until the first commit.
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank    <= '1;
            sh_hex      <= 1'b0;
            sh_lzs      <= 1'b0;
            disp_digits <= '0;
            disp_dp     <= '0;
            disp_blank  <= '1;
            disp_hex    <= 1'b0;
            disp_lzs    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            state       <= state_nxt;
            pending     <= pending_nxt;
            disp_digits <= disp_digits_nxt;
            disp_dp     <= disp_dp_nxt;
            disp_blank  <= disp_blank_nxt;
            disp_hex    <= disp_hex_nxt;
            disp_lzs    <= disp_lzs_nxt;
            if (load) begin
                sh_digits <= digits_in;
                sh_dp     <= dp_in;
                sh_blank  <= blank_in;
                sh_hex    <= hex_mode;
                sh_lzs    <= lzs_en;
            end
        end
    end

    // Registered pin drivers; a blank_in digit keeps its decimal point dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_out     <= '1;
            cc_out     <= SEG_BLANK;
            dp_out     <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an_out     <= an_nxt;
            cc_out     <= sel_seg;
            dp_out     <= !(sel_dp && !sel_blank);
            frame_tick <= frame_wrap;
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
// Self-checking bench for ssd_mux_driver with 4 digits and 4-cycle slots.
// Expected per-cycle pin values of a whole frame are queued when a load is
// driven and popped once per cycle while that frame is scanned.
module tb_ssd_mux_driver;

    localparam int ND     = 4;
    localparam int RD     = 4;
    localparam int FRAME  = ND * RD;
    localparam int BUDGET = 3 * FRAME;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SF = 7'b0001110;
    localparam logic [6:0] BL = 7'h7F;

    // {frame_tick, an_out, cc_out, dp_out} while in reset
    localparam logic [12:0] RESET_PINS = {1'b0, 4'hF, 7'h7F, 1'b1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in;
    logic [3:0]    blank_in;
    logic          hex_mode;
    logic          lzs_en;
    logic          load;
    logic [3:0]    an_out;
    logic [6:0]    cc_out;
    logic          dp_out;
    logic          frame_tick;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [12:0]   exp_q[$];
    int            cyc;

    ssd_mux_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .hex_mode   (hex_mode),
        .lzs_en     (lzs_en),
        .load       (load),
        .an_out     (an_out),
        .cc_out     (cc_out),
        .dp_out     (dp_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [12:0] pins();
        return {frame_tick, an_out, cc_out, dp_out};
    endfunction

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (tick,an,cc,dp)", tag, got, exp);
        end
    endtask

    // Steps to the next negedge on which frame_tick is high, bounded.
    task automatic wait_tick(input string tag, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        while (!found && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            found = frame_tick;
        end
        if (!found) check({tag, "_tick_timeout"}, {12'b0, frame_tick}, 13'd1);
    endtask

    task automatic pulse_load(input logic [15:0] d, input logic [3:0] dp,
                              input logic [3:0] bl, input logic hx, input logic lz);
        digits_in = d;
        dp_in     = dp;
        blank_in  = bl;
        hex_mode  = hx;
        lzs_en    = lz;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // segs = {d3,d2,d1,d0} patterns, dpn = active-low dp per digit {d3..d0}.
    task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpn);
        logic       ft;
        logic [3:0] an;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < RD; c++) begin
                ft = (d == 0) && (c == 0);
                an = (c == 0) ? 4'hF : ~(4'b0001 << d);
                exp_q.push_back({ft, an, segs[7*d +: 7], dpn[d]});
            end
        end
    endtask

    // Compares one full frame; starts at the current negedge unless told to wait.
    task automatic check_frame(input string tag, input bit wait_first);
        int c;
        if (wait_first) wait_tick(tag, c);
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (exp_q.size() > 0) check(tag, pins(), exp_q.pop_front());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        digits_in = '0;
        dp_in     = '0;
        blank_in  = '0;
        hex_mode  = 1'b0;
        lzs_en    = 1'b0;
        load      = 1'b0;

        repeat (20) begin
            @(negedge clk);
            check("reset_hold", pins(), RESET_PINS);
        end
        rst_n = 1'b1;
        wait_tick("reset_release", cyc);
        check("reset_latency", 13'(cyc), 13'(FRAME));
        push_frame({BL, BL, BL, BL}, 4'b1111);
        check_frame("blank_after_reset", 1'b0);

        // Plain decimal digits, then input changes without load must not show.
        wait_tick("load_1234", cyc);
        pulse_load(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0);
        push_frame({S1, S2, S3, S4}, 4'b1111);
        check_frame("digits_1234", 1'b1);
        digits_in = 16'h9999;
        dp_in     = 4'b1111;
        push_frame({S1, S2, S3, S4}, 4'b1111);
        check_frame("no_load_no_change", 1'b1);

        // Leading-zero suppression with a letter code in decimal and hex mode.
        wait_tick("load_00a5_dec", cyc);
        pulse_load(16'h00A5, 4'b0000, 4'b0000, 1'b0, 1'b1);
        push_frame({BL, BL, BL, S5}, 4'b1111);
        check_frame("lzs_dec_a5", 1'b1);
        wait_tick("load_00a5_hex", cyc);
        pulse_load(16'h00A5, 4'b0000, 4'b0000, 1'b1, 1'b1);
        push_frame({BL, BL, SA, S5}, 4'b1111);
        check_frame("lzs_hex_a5", 1'b1);

        // Remaining patterns: letters b,C,d with 9, and 6,7 with trailing zeros kept.
        wait_tick("load_bcd9", cyc);
        pulse_load(16'hBCD9, 4'b0000, 4'b0000, 1'b1, 1'b0);
        push_frame({SB, SC, SD, S9}, 4'b1111);
        check_frame("hex_bcd9", 1'b1);
        wait_tick("load_6700", cyc);
        pulse_load(16'h6700, 4'b0000, 4'b0000, 1'b0, 1'b1);
        push_frame({S6, S7, S0, S0}, 4'b1111);
        check_frame("lzs_keep_trailing", 1'b1);

        // Two loads in one frame: the second wins; a dp stops suppression.
        wait_tick("load_twice", cyc);
        pulse_load(16'h9999, 4'b0000, 4'b0000, 1'b0, 1'b0);
        pulse_load(16'h0000, 4'b0100, 4'b0000, 1'b0, 1'b1);
        push_frame({BL, S0, S0, S0}, 4'b1011);
        check_frame("last_load_wins_dp", 1'b1);

        // Load captured on the wrap edge: old frame once more, new frame after.
        pulse_load(16'h8F7E, 4'b0001, 4'b0010, 1'b1, 1'b0);
        push_frame({BL, S0, S0, S0}, 4'b1011);
        push_frame({S8, SF, BL, SE}, 4'b1110);
        check_frame("wrap_load_old", 1'b0);
        check_frame("wrap_load_new", 1'b1);

        // Reset asserted mid-DRIVE acts without a clock edge.
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", pins(), RESET_PINS);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_tick("midreset_release", cyc);
        check("midreset_latency", 13'(cyc), 13'(FRAME));
        push_frame({BL, BL, BL, BL}, 4'b1111);
        check_frame("blank_after_midreset", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
